// File: rtl/mic_tdm_sched.sv
// 4-mic I2S TDM frame scheduler: one holding register per channel, serial output MSB-first, lrclk one bit ahead.
// Optional MIC_TDM_UNDERRUN_CNT_EN adds a saturating underrun counter and makes underrun flags per-frame.
module mic_tdm_sched #(
    parameter int WORD_LEN = 16,
    parameter int CLK_DIV  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3:0]            ch_valid,
    input  logic [4*WORD_LEN-1:0] ch_data,
    output logic [3:0]            ch_ready,
    output logic                  i2s_clk,
    output logic                  i2s_lrclk,
    output logic                  i2s_data,
    output logic                  frame_start,
    output logic [3:0]            underrun,
`ifdef MIC_TDM_UNDERRUN_CNT_EN
    output logic [15:0]           underrun_cnt,
`endif
    output logic                  busy
);

    localparam int FRAME_BITS = 4 * WORD_LEN;
    localparam int K_W        = $clog2(FRAME_BITS);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST = K_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [WORD_LEN-1:0] hold [4];
    logic [3:0]          full;
    logic [WORD_LEN-1:0] shreg;
    logic [DIV_W-1:0]    div;
    logic [K_W-1:0]      k;
`ifdef MIC_TDM_UNDERRUN_CNT_EN
    logic [3:0]          frame_flags;
`endif

    logic                div_tc;
    logic                fall;
    logic [1:0]          slot;
    logic                slot_load;
    logic [K_W-1:0]      k_next;
    logic                next_ws;
    logic                load_empty;
    logic [WORD_LEN-1:0] load_word;

    // k is the index of the bit launched at the next falling edge.
    always_comb begin
        div_tc     = (div == DIV_TC);
        fall       = (state != IDLE) && div_tc && i2s_clk;
        slot       = 2'(32'(k) / WORD_LEN);
        slot_load  = ((32'(k) % WORD_LEN) == 0);
        k_next     = (k == K_LAST) ? '0 : k + K_W'(1);
        next_ws    = ((32'(k_next) / WORD_LEN) >= 2);
        load_empty = ~full[slot];
        load_word  = full[slot] ? hold[slot] : '0;
    end

    assign ch_ready = ~full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            full        <= '0;
            shreg       <= '0;
            div         <= '0;
            k           <= '0;
            i2s_clk     <= 1'b0;
            i2s_lrclk   <= 1'b0;
            i2s_data    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= '0;
            busy        <= 1'b0;
            for (int n = 0; n < 4; n++) hold[n] <= '0;
`ifdef MIC_TDM_UNDERRUN_CNT_EN
            underrun_cnt <= '0;
            frame_flags  <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                if (ch_valid[n] && !full[n]) begin
                    hold[n] <= ch_data[n*WORD_LEN +: WORD_LEN];
                    full[n] <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    i2s_clk   <= 1'b0;
                    i2s_lrclk <= 1'b0;
                    i2s_data  <= 1'b0;
                    // The start cycle already counts as the first divider step.
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        if (div_tc) i2s_clk <= 1'b1;
                        else        div     <= div + DIV_W'(1);
                    end
                end
                default: begin
                    if (state == RUN && !enable) state <= DRAIN;
                    if (!div_tc) begin
                        div <= div + DIV_W'(1);
                    end else begin
                        div     <= '0;
                        i2s_clk <= ~i2s_clk;
                        if (fall) begin
                            // In DRAIN, k back at 0 means bit 63 has just completed.
                            if (state == DRAIN && k == '0) begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                i2s_data  <= 1'b0;
                                i2s_lrclk <= 1'b0;
                            end else begin
                                k         <= k_next;
                                i2s_lrclk <= next_ws;
                                if (slot_load) begin
                                    i2s_data <= load_word[WORD_LEN-1];
                                    shreg    <= load_word << 1;
                                    if (slot == 2'd0) frame_start <= 1'b1;
                                    if (!load_empty) begin
                                        full[slot] <= 1'b0;
                                    end else begin
`ifdef MIC_TDM_UNDERRUN_CNT_EN
                                        if (underrun_cnt != 16'hFFFF)
                                            underrun_cnt <= underrun_cnt + 16'd1;
`else
                                        underrun[slot] <= 1'b1;
`endif
                                    end
`ifdef MIC_TDM_UNDERRUN_CNT_EN
                                    // Slot 0 publishes the flags of the frame just finished.
                                    if (slot == 2'd0) begin
                                        underrun    <= frame_flags;
                                        frame_flags <= {3'b000, load_empty};
                                    end else begin
                                        frame_flags[slot] <= load_empty;
                                    end
`endif
                                end else begin
                                    i2s_data <= shreg[WORD_LEN-1];
                                    shreg    <= shreg << 1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_tdm_sched.sv
// Randomized bench for mic_tdm_sched: a receiver captures bits on i2s_clk rises and compares
// whole frames against the words the bench scheduled per channel.
module tb_mic_tdm_sched;
    localparam int WL         = 16;
    localparam int CD         = 2;
    localparam int FRAME_CLKS = 4 * WL * 2 * CD;
    localparam int MAXF       = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [3:0]      ch_valid = '0;
    logic [4*WL-1:0] ch_data = '0;
    logic [3:0]      ch_ready;
    logic            i2s_clk, i2s_lrclk, i2s_data, frame_start, busy;
    logic [3:0]      underrun;
`ifdef MIC_TDM_UNDERRUN_CNT_EN
    logic [15:0]     underrun_cnt;
`endif

    mic_tdm_sched #(.WORD_LEN(WL), .CLK_DIV(CD)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ch_valid(ch_valid),
        .ch_data(ch_data),
        .ch_ready(ch_ready),
        .i2s_clk(i2s_clk),
        .i2s_lrclk(i2s_lrclk),
        .i2s_data(i2s_data),
        .frame_start(frame_start),
        .underrun(underrun),
`ifdef MIC_TDM_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver / source state, all updated from tick()
    int          cyc = 0;
    logic        prev_clk = 1'b0;
    logic        prev_busy = 1'b0;
    logic        rst_edge;
    logic [3:0]  rdy_seen = '0;
    logic [15:0] pend [4][$];
    int          dly  [4][$];
    bit          stream = 0;
    logic [15:0] stream_val = '0;
    bit          rx_on = 0;
    bit          first_fall_pending = 1;
    bit          fall_now, rise_now;
    int          cur_bit = 0;
    int          fs_cnt = 0;
    int          last_fs_cyc = 0;
    int          last_fall_cyc = 0;
    int          busy_fall_cyc = -1;
    bit          rx_bits[$];
    bit          rx_lr[$];

    logic [15:0] plan_w    [MAXF][4];
    bit          plan_skip [MAXF][4];

    task automatic tick();
        rst_edge = reset;
        @(posedge clk);
        #1;
        cyc++;
        rise_now = !prev_clk && i2s_clk;
        fall_now = prev_clk && !i2s_clk;
        if (fall_now) begin
            cur_bit = frame_start ? 0 : cur_bit + 1;
            last_fall_cyc = cyc;
        end
        if (!rst_edge) begin
            for (int n = 0; n < 4; n++) begin
                if (ch_valid[n] && rdy_seen[n]) begin
                    check($sformatf("rdy_drop_ch%0d", n), ch_ready[n], 1'b0);
                    void'(pend[n].pop_front());
                    void'(dly[n].pop_front());
                end
            end
            if (stream && !rdy_seen[1] && ch_ready[1])
                check("rdy1_rise_after_k16", (fall_now && cur_bit == 16), 1);
        end
        if (frame_start) begin
            if (fs_cnt > 0) check("frame_spacing", cyc - last_fs_cyc, FRAME_CLKS);
            last_fs_cyc = cyc;
            fs_cnt++;
            rx_on = 1;
        end
        if (fall_now && first_fall_pending) begin
            check("first_fall_is_k0", frame_start, 1'b1);
            first_fall_pending = 0;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        if (rise_now && rx_on) begin
            rx_bits.push_back(i2s_data);
            rx_lr.push_back(i2s_lrclk);
        end
        prev_clk  = i2s_clk;
        prev_busy = busy;
        rdy_seen  = ch_ready;
        if (stream && pend[1].size() == 0) begin
            pend[1].push_back(stream_val);
            dly[1].push_back(0);
            stream_val = stream_val + 16'd1;
        end
        for (int n = 0; n < 4; n++) begin
            if (pend[n].size() > 0 && dly[n][0] == 0) begin
                ch_valid[n] = 1'b1;
                ch_data[n*WL +: WL] = pend[n][0];
            end else begin
                ch_valid[n] = 1'b0;
                if (pend[n].size() > 0) dly[n][0] = dly[n][0] - 1;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_outs"}, {i2s_clk, i2s_lrclk, i2s_data, frame_start, busy}, 5'b0);
        check({tag, "_underrun"}, underrun, 4'h0);
        check({tag, "_ready"}, ch_ready, 4'hF);
`ifdef MIC_TDM_UNDERRUN_CNT_EN
        check({tag, "_ucnt"}, underrun_cnt, 16'h0);
`endif
    endtask

    task automatic do_reset(input string tag);
        reset  = 1'b1;
        enable = 1'b0;
        stream = 0;
        for (int n = 0; n < 4; n++) begin
            pend[n].delete();
            dly[n].delete();
        end
        ch_valid = '0;
        tick();
        chk_reset(tag);
        reset = 1'b0;
    endtask

    task automatic plan_random(input int f, input int skip_pct);
        for (int n = 0; n < 4; n++) begin
            plan_w[f][n]    = 16'($urandom);
            plan_skip[f][n] = ($urandom_range(0, 99) < skip_pct);
        end
    endtask

    task automatic enqueue_frame(input int f);
        for (int n = 0; n < 4; n++) begin
            if (!(stream && n == 1) && !plan_skip[f][n]) begin
                pend[n].push_back(plan_w[f][n]);
                dly[n].push_back($urandom_range(0, 6));
            end
        end
    endtask

    task automatic wait_frame(input int f);
        for (int t = 0; t < FRAME_CLKS + 64 && fs_cnt < f + 1; t++) tick();
        if (fs_cnt < f + 1) check($sformatf("frame%0d_timeout", f), fs_cnt, f + 1);
    endtask

    task automatic wait_bit(input int b);
        for (int t = 0; t < FRAME_CLKS && cur_bit < b; t++) tick();
        if (cur_bit < b) check($sformatf("bit%0d_timeout", b), cur_bit, b);
    endtask

    task automatic run_frames(input int nf, input bit abort_run);
        int          nfull;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_u;
        int          tot_u;
        logic [15:0] w;
        logic [63:0] lr_got, lr_exp;
        fs_cnt = 0;
        rx_on = 0;
        rx_bits.delete();
        rx_lr.delete();
        first_fall_pending = 1;
        busy_fall_cyc = -1;
        if (stream) begin
            for (int f = 0; f < nf; f++) begin
                plan_w[f][1]    = stream_val + 16'(f);
                plan_skip[f][1] = 0;
            end
        end
        enqueue_frame(0);
        for (int t = 0; t < 12; t++) tick();
        for (int n = 0; n < 4; n++) exp_rdy[n] = plan_skip[0][n];
        check("preload_ready", ch_ready, exp_rdy);
        enable = 1'b1;
        for (int f = 0; f < nf; f++) begin
            wait_frame(f);
            if (f == nf - 1) begin
                if (abort_run) begin
                    wait_bit(40);
                    do_reset("midreset");
                end else begin
                    wait_bit(10);
                    enable = 1'b0;
                end
            end else begin
                wait_bit(49);
                enqueue_frame(f + 1);
            end
        end
        nfull = abort_run ? nf - 1 : nf;
        if (!abort_run) begin
            for (int t = 0; t < 2 * FRAME_CLKS && busy; t++) tick();
            check("busy_fall_at_last_fall", busy_fall_cyc, last_fall_cyc);
            check("i2s_clk_rest", i2s_clk, 1'b0);
            for (int t = 0; t < 12; t++) tick();
            check("idle_quiet", {i2s_clk, busy}, 2'b00);
            check("rx_bit_count", rx_bits.size(), 64 * nf);
            check("frame_count", fs_cnt, nf);
        end
        if (rx_bits.size() < 64 * nfull) begin
            check("rx_short", rx_bits.size(), 64 * nfull);
        end else begin
            for (int f = 0; f < nfull; f++) begin
                for (int n = 0; n < 4; n++) begin
                    for (int b = 0; b < WL; b++) w[WL-1-b] = rx_bits[f*64 + n*WL + b];
                    check($sformatf("data_f%0d_ch%0d", f, n), w,
                          plan_skip[f][n] ? 16'h0 : plan_w[f][n]);
                end
                for (int j = 0; j < 64; j++) begin
                    lr_got[63-j] = rx_lr[f*64 + j];
                    lr_exp[63-j] = ((((j + 1) % 64) / WL) >= 2);
                end
                check($sformatf("lrclk_f%0d", f), lr_got, lr_exp);
            end
        end
        if (!abort_run) begin
            exp_u = '0;
            tot_u = 0;
            for (int f = 0; f < nf; f++)
                for (int n = 0; n < 4; n++)
                    if (plan_skip[f][n]) begin
                        exp_u[n] = 1'b1;
                        tot_u++;
                    end
`ifdef MIC_TDM_UNDERRUN_CNT_EN
            for (int n = 0; n < 4; n++) exp_u[n] = plan_skip[nf-2][n];
            check("underrun_cnt", underrun_cnt, tot_u);
`endif
            check("underrun", underrun, exp_u);
        end
    endtask

    initial begin
        int t;
        // Reset held with enable high, then first i2s_clk edge timing
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset($sformatf("rst%0d", i));
        end
        reset = 1'b0;
        t = 0;
        do begin tick(); t++; end while (!i2s_clk && t < 20);
        check("first_rise_clks", t, 2);
        t = 0;
        do begin tick(); t++; end while (!rise_now && t < 20);
        check("i2s_period_clks", t, 4);
        do_reset("rstA");

        // Known-pattern frame followed by random frames
        plan_w[0][0] = 16'hA5A5; plan_w[0][1] = 16'h8001;
        plan_w[0][2] = 16'h0000; plan_w[0][3] = 16'hFFFF;
        for (int n = 0; n < 4; n++) plan_skip[0][n] = 0;
        plan_random(1, 0);
        plan_random(2, 0);
        run_frames(3, 0);
        do_reset("rstB");

        // Channel 3 missing in the first frame only
        plan_random(0, 0);
        plan_skip[0][3] = 1;
        plan_random(1, 0);
        run_frames(2, 0);
        do_reset("rstC");

        // Channel 1 streamed continuously, random underruns elsewhere
        stream = 1;
        stream_val = 16'($urandom);
        for (int f = 0; f < 4; f++) plan_random(f, 25);
        run_frames(4, 0);
        do_reset("rstD");

        // Reset in the middle of the second frame, then restart
        plan_random(0, 0);
        plan_random(1, 0);
        run_frames(2, 1);
        plan_random(0, 10);
        plan_random(1, 10);
        run_frames(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_tdm_sched.md
Name: mic_tdm_sched

Overview:
- Frame scheduler for the 4-microphone I2S output path.
- Accepts one 16-bit sample per mic channel through per-channel valid/ready, and owns the shared serial output.
- Generates i2s_clk and i2s_lrclk from the system clock.
- Each frame visits channels in fixed order 0,1,2,3 and serializes each sample MSB-first in I2S format: L pair = ch0/ch1, R pair = ch2/ch3.

Parameters:
- WORD_LEN, 16: bits per slot; 4 slots per frame.
- CLK_DIV, 4: clk cycles per i2s_clk half-period (≥1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous active-high reset.
- enable  input  1  run request.
- ch_valid  input  4  per-channel sample valid.
- ch_data  input  4*WORD_LEN  channel n sample at [n*WORD_LEN +: WORD_LEN].
- ch_ready  output  4  per-channel holding register empty.
- i2s_clk  output  1  bit clock.
- i2s_lrclk  output  1  frame/word select.
- i2s_data  output  1  serial data.
- frame_start  output  1  one-clk pulse at the MSB launch of slot 0.
- underrun  output  4  sticky: slot n launched with no sample held.
- busy  output  1  high in RUN and DRAIN.

Behaviour:
- Reset values:
  - i2s_clk = 0, i2s_lrclk = 0, i2s_data = 0, frame_start = 0.
  - underrun = 0, busy = 0, ch_ready = 4'hF.
  - All holding registers empty; div counter = 0; bit index k = 0.
- Reset takes effect in any state, mid-frame included. The current frame is abandoned; no partial word is flushed.
- Holding registers (one per channel):
  - ch_ready[n] = ~full[n], registered.
  - A write is accepted when ch_valid[n] & ch_ready[n]. full[n] sets on the next clk.
  - Writes are accepted in every state, IDLE included.
- FSM states:
  - IDLE: i2s_clk held low; data and lrclk held 0. Moves to RUN when enable=1.
  - RUN: div counter counts 0..CLK_DIV-1; at terminal count i2s_clk toggles and the counter wraps.
  - Falling-edge event (i2s_clk 1→0) in RUN:
    - k advances modulo 4*WORD_LEN.
    - i2s_data <= shift-register MSB; the register then shifts left.
  - DRAIN: entered when enable=0 is sampled during RUN. Continues until the falling edge completing k=4*WORD_LEN-1, then enters IDLE with i2s_clk=0.
  - enable re-asserted during DRAIN has no effect until IDLE is reached.
- Slot load:
  - At the falling edge where k = n*WORD_LEN, the slot-n shift register loads.
  - If full[n]: load holding[n], clear full[n]. The clear wins over any same-cycle write, since ready was 0.
  - Else: load zero and set underrun[n].
  - The loaded MSB appears on i2s_data at that same edge.
- First frame after IDLE: the first falling edge corresponds to k=0.
- lrclk (I2S one-bit lead):
  - Updated on every falling edge to the word-select value of bit k+1.
  - 1 when slot(k+1) ∈ {2,3}, otherwise 0.
  - So lrclk leads data by one bit clock and changes at k = 2*WORD_LEN-1 and k = 4*WORD_LEN-1.
- frame_start: high for exactly one clk, the cycle the k=0 load occurs.
- underrun: sticky. Cleared only by reset, or per the optional feature.
- Width rules: k width = clog2(4*WORD_LEN); div counter width = clog2(CLK_DIV).

Optional Feature:
- Macro: MIC_TDM_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt (16 bits).
  - Increments once per underrun slot launch, saturating at 16'hFFFF.
  - Cleared by reset.
  - underrun becomes clear-on-frame: it shows only the flags of the most recent completed frame, updated at each frame_start.
- When undefined: no counter port; underrun is purely sticky.

Test Plan:
- Reset sequencing: reset=1 with enable=1 for 3 clks, then release → all outputs at reset values during reset. With CLK_DIV=2, the first i2s_clk rise occurs 2 clks after release and one i2s_clk period is 4 clks.
- Full frame: preload ch0..3 = 16'hA5A5, 16'h8001, 16'h0000, 16'hFFFF, then enable → i2s_data sequence matches these 64 bits MSB-first. lrclk=1 from bit 31 through bit 62 and 0 at bit 63. frame_start pulses once per 64 bit clocks. underrun=0.
- Underrun: only ch0..2 loaded → slot 3 transmits 16 zeros and underrun=4'b1000. With the macro defined, underrun_cnt=1.
- Backpressure: hold ch_valid[1]=1 continuously with an incrementing value → ch_ready[1] drops the cycle after acceptance. It re-asserts the clk after the k=16 load. Exactly one word is transmitted per frame and no word is lost or duplicated.
- Drain: deassert enable at k=10 → the frame completes all 64 bits, busy falls the clk after the final falling edge, and i2s_clk rests at 0.
- Mid-frame reset: assert reset at k=40 → the next clk shows reset values. Held samples are discarded (ch_ready=4'hF), and after re-enable transmission restarts at k=0.
